// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment display path.
package display_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    // Common-anode display: a 1 on an anode line keeps that digit dark.
    localparam logic [MAX_DIGITS-1:0] AN_ALL_OFF = '1;

    typedef logic [$clog2(MAX_DIGITS)-1:0] digit_idx_t;

    // 100 MHz clock: 1 kHz per digit, 10 us dark gap at the start of each slot.
    localparam int DEFAULT_REFRESH_DIV  = 100000;
    localparam int DEFAULT_BLANK_CYCLES = 1000;

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running slot timer: counts 0..DIV-1 and flags the last cycle of each slot.
module refresh_prescaler #(
    parameter int DIV = 100000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic [$clog2(DIV)-1:0] count,
    output logic                   tc
);

    localparam int             CW   = $clog2(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Wrap to zero on the terminal count, otherwise advance.
    always_comb begin
        tc      = (count_q == LAST);
        count_d = tc ? '0 : count_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/digit_scan_mux.sv
// Scans a packed multi-digit hex value onto a common-anode seven-segment
// display. Inputs are captured once per frame so a frame never mixes old and
// new data; leading zeros can be blanked and every slot opens with a short
// all-dark gap to suppress ghosting between adjacent digits.
module digit_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = DEFAULT_REFRESH_DIV,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]         dp_mask,
    input  logic                          lz_blank,
    output logic [DIGIT_W-1:0]            digit,
    output logic                          dp_out,
    output logic [NUM_DIGITS-1:0]         AN,
    output logic                          frame_tick
);

    localparam int                    CNT_W     = $clog2(REFRESH_DIV);
    localparam int                    IDX_W     = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_ALL_OFF[NUM_DIGITS-1:0];

    logic [CNT_W-1:0] cnt;
    logic             tc;

    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          load_pending_q, load_pending_d;
    logic [DIGIT_W*NUM_DIGITS-1:0] sh_value_q, sh_value_d;
    logic [NUM_DIGITS-1:0]         sh_dp_q, sh_dp_d;
    logic                          sh_lz_q, sh_lz_d;
    logic                          frame_tick_q, frame_tick_d;
    logic [DIGIT_W-1:0]            digit_q, digit_d;
    logic                          dp_q, dp_d;
    logic [NUM_DIGITS-1:0]         an_q, an_d;

    logic                          capture;
    logic                          zero_run;
    logic [NUM_DIGITS-1:0]         blanked;

    refresh_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .count   (cnt),
        .tc      (tc)
    );

    // Slot sequencing and once-per-frame capture; the capture edge is also
    // the wrap back to digit 0, so slot 0 always sees the fresh frame.
    always_comb begin
        idx_d          = idx_q;
        sh_value_d     = sh_value_q;
        sh_dp_d        = sh_dp_q;
        sh_lz_d        = sh_lz_q;
        capture        = load_pending_q || (tc && (idx_q == LAST_IDX));
        load_pending_d = load_pending_q && !capture;
        frame_tick_d   = capture;
        if (tc) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        if (capture) begin
            sh_value_d = value;
            sh_dp_d    = dp_mask;
            sh_lz_d    = lz_blank;
        end
    end

    // Leading-zero mask: a digit blanks when it and everything to its left is
    // zero. Digit 0 is excluded so a zero value still shows a single "0".
    always_comb begin
        zero_run = sh_lz_q;
        blanked  = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (sh_value_q[k*DIGIT_W +: DIGIT_W] == '0);
            blanked[k] = zero_run;
        end
    end

    // Select the current digit's nibble, DP and anode; only one anode can be
    // low, and none during the anti-ghosting gap or on a blanked digit.
    always_comb begin
        digit_d = '0;
        dp_d    = 1'b0;
        an_d    = AN_OFF;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx_t'(idx_q) == digit_idx_t'(k)) begin
                digit_d = sh_value_q[k*DIGIT_W +: DIGIT_W];
                dp_d    = sh_dp_q[k];
                if (!(cnt < BLANK_END) && !blanked[k]) begin
                    an_d[k] = 1'b0;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q          <= '0;
            load_pending_q <= 1'b1;
            sh_value_q     <= '0;
            sh_dp_q        <= '0;
            sh_lz_q        <= 1'b0;
            frame_tick_q   <= 1'b0;
            digit_q        <= '0;
            dp_q           <= 1'b0;
            an_q           <= AN_OFF;
        end else begin
            idx_q          <= idx_d;
            load_pending_q <= load_pending_d;
            sh_value_q     <= sh_value_d;
            sh_dp_q        <= sh_dp_d;
            sh_lz_q        <= sh_lz_d;
            frame_tick_q   <= frame_tick_d;
            digit_q        <= digit_d;
            dp_q           <= dp_d;
            an_q           <= an_d;
        end
    end

    assign digit      = digit_q;
    assign dp_out     = dp_q;
    assign AN         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Bench for digit_scan_mux with short slots (8 cycles, 2-cycle gap, 4 digits).
module tb_digit_scan_mux;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic [15:0] value    = '0;
    logic [3:0]  dp_mask  = '0;
    logic        lz_blank = 1'b0;
    logic [3:0]  digit;
    logic        dp_out;
    logic [3:0]  AN;
    logic        frame_tick;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: position in time since reset release plus the frame
    // data latched at each capture.
    int          s;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_lz;
    logic [3:0]  exp_digit;
    logic        exp_dp;
    logic [3:0]  exp_an;
    logic        exp_tick;

    digit_scan_mux #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .value      (value),
        .dp_mask    (dp_mask),
        .lz_blank   (lz_blank),
        .digit      (digit),
        .dp_out     (dp_out),
        .AN         (AN),
        .frame_tick (frame_tick)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1);
    end

    // Anode invariant: never more than one digit enabled.
    always @(negedge clk) begin
        n_cmp++;
        if ($countones(~AN) > 1) begin
            n_fail++;
            $display("FAIL one_hot_an: AN=%b, want at most one low bit", AN);
        end
    end

    task automatic model_reset();
        s         = 0;
        m_val     = '0;
        m_dp      = '0;
        m_lz      = 1'b0;
        exp_digit = '0;
        exp_dp    = 1'b0;
        exp_an    = 4'hF;
        exp_tick  = 1'b0;
    endtask

    // One clock: at the edge the model works out what the display must show
    // for the slot position it was in, then latches a new frame if due.
    task automatic step();
        int  idx;
        int  pos;
        bit  blk;
        bit  cap;
        @(posedge clk);
        if (reset_n) begin
            idx       = (s / RD) % ND;
            pos       = s % RD;
            blk       = m_lz && (idx != 0) && ((m_val >> (4 * idx)) == 16'h0);
            exp_digit = 4'((m_val >> (4 * idx)) & 16'hF);
            exp_dp    = m_dp[idx];
            exp_an    = (pos < BC || blk) ? 4'hF : (4'hF & ~(4'h1 << idx));
            cap       = (s == 0) || (s % FRAME == FRAME - 1);
            if (cap) begin
                m_val = value;
                m_dp  = dp_mask;
                m_lz  = lz_blank;
            end
            exp_tick = cap;
            s++;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        value   = 16'h1234;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (AN !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_an: got %b, want 1111", AN);
        end
        n_cmp++;
        if (digit !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_digit: got %h, want 0", digit);
        end
        n_cmp++;
        if (dp_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dp: got %b, want 0", dp_out);
        end
        n_cmp++;
        if (frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tick: got %b, want 0", frame_tick);
        end
    endtask

    task automatic test_basic_scan();
        value    = 16'h1234;
        dp_mask  = 4'b0000;
        lz_blank = 1'b0;
        apply_reset();
        step();
        n_cmp++;
        if (frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_first_tick: got %b, want 1", frame_tick);
        end
        for (int i = 1; i < FRAME + 8; i++) begin
            step();
            n_cmp++;
            if ({digit, dp_out, AN, frame_tick} !== {exp_digit, exp_dp, exp_an, exp_tick}) begin
                n_fail++;
                $display("FAIL basic cyc=%0d: got d=%h dp=%b an=%b t=%b, want d=%h dp=%b an=%b t=%b",
                         i, digit, dp_out, AN, frame_tick, exp_digit, exp_dp, exp_an, exp_tick);
            end
        end
    endtask

    task automatic test_lz_blank();
        int lit_hi;
        int lit_1;
        value    = 16'h0050;
        lz_blank = 1'b1;
        lit_hi   = 0;
        lit_1    = 0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            step();
            n_cmp++;
            if ({digit, dp_out, AN, frame_tick} !== {exp_digit, exp_dp, exp_an, exp_tick}) begin
                n_fail++;
                $display("FAIL lz cyc=%0d: got d=%h dp=%b an=%b t=%b, want d=%h dp=%b an=%b t=%b",
                         i, digit, dp_out, AN, frame_tick, exp_digit, exp_dp, exp_an, exp_tick);
            end
            if (i >= FRAME + 2) begin
                if (AN[3] == 1'b0 || AN[2] == 1'b0) lit_hi++;
                if (AN[1] == 1'b0) lit_1++;
            end
        end
        n_cmp++;
        if (lit_hi !== 0) begin
            n_fail++;
            $display("FAIL lz_upper_dark: got %0d lit cycles, want 0", lit_hi);
        end
        n_cmp++;
        if (lit_1 !== RD - BC) begin
            n_fail++;
            $display("FAIL lz_digit1_lit: got %0d lit cycles, want %0d", lit_1, RD - BC);
        end
    endtask

    task automatic test_zero_value();
        int lit_0;
        int bad;
        value    = 16'h0000;
        lz_blank = 1'b1;
        lit_0    = 0;
        bad      = 0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            step();
            n_cmp++;
            if ({digit, dp_out, AN, frame_tick} !== {exp_digit, exp_dp, exp_an, exp_tick}) begin
                n_fail++;
                $display("FAIL zero cyc=%0d: got d=%h dp=%b an=%b t=%b, want d=%h dp=%b an=%b t=%b",
                         i, digit, dp_out, AN, frame_tick, exp_digit, exp_dp, exp_an, exp_tick);
            end
            if (i >= FRAME + 2) begin
                if (AN == 4'b1110) lit_0++;
                else if (AN != 4'b1111) bad++;
                if (digit != 4'h0) bad++;
            end
        end
        n_cmp++;
        if (lit_0 !== RD - BC || bad !== 0) begin
            n_fail++;
            $display("FAIL zero_only_digit0: got lit=%0d bad=%0d, want lit=%0d bad=0",
                     lit_0, bad, RD - BC);
        end
    endtask

    task automatic test_dp_and_hold();
        int  dp_cnt;
        int  old_bad;
        int  new_bad;
        bit  seen;
        value    = 16'hABCD;
        dp_mask  = 4'b0100;
        lz_blank = 1'b0;
        dp_cnt   = 0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            step();
            n_cmp++;
            if ({digit, dp_out, AN, frame_tick} !== {exp_digit, exp_dp, exp_an, exp_tick}) begin
                n_fail++;
                $display("FAIL dp cyc=%0d: got d=%h dp=%b an=%b t=%b, want d=%h dp=%b an=%b t=%b",
                         i, digit, dp_out, AN, frame_tick, exp_digit, exp_dp, exp_an, exp_tick);
            end
            if (i >= FRAME + 2 && dp_out) begin
                dp_cnt++;
                n_cmp++;
                if (digit !== 4'hB) begin
                    n_fail++;
                    $display("FAIL dp_on_digit: got digit %h with dp, want b", digit);
                end
            end
        end
        n_cmp++;
        if (dp_cnt !== RD) begin
            n_fail++;
            $display("FAIL dp_count: got %0d dp cycles per frame, want %0d", dp_cnt, RD);
        end
        // Mid-frame change: old frame must persist until the next capture.
        repeat (5) step();
        value   = 16'h1111;
        old_bad = 0;
        new_bad = 0;
        seen    = 1'b0;
        for (int i = 0; i < FRAME + 2 && !seen; i++) begin
            step();
            if (digit < 4'hA) old_bad++;
            if (frame_tick) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL hold_tick_timeout: got no frame_tick, want one within %0d cycles", FRAME + 2);
        end
        n_cmp++;
        if (old_bad !== 0) begin
            n_fail++;
            $display("FAIL hold_old_frame: got %0d non-ABCD cycles, want 0", old_bad);
        end
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (digit !== 4'h1) new_bad++;
        end
        n_cmp++;
        if (new_bad !== 0) begin
            n_fail++;
            $display("FAIL hold_new_frame: got %0d non-1 cycles, want 0", new_bad);
        end
    endtask

    task automatic test_reset_mid_slot();
        value    = 16'h1234;
        dp_mask  = 4'b0100;
        lz_blank = 1'b0;
        apply_reset();
        repeat (2 * RD + 5) step();
        n_cmp++;
        if (digit !== 4'h2 || AN !== 4'b1011) begin
            n_fail++;
            $display("FAIL pre_reset_slot: got d=%h an=%b, want d=2 an=1011", digit, AN);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (AN !== 4'hF || digit !== 4'h0 || dp_out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got d=%h dp=%b an=%b, want d=0 dp=0 an=1111", digit, dp_out, AN);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < FRAME + 4; i++) begin
            step();
            n_cmp++;
            if ({digit, dp_out, AN, frame_tick} !== {exp_digit, exp_dp, exp_an, exp_tick}) begin
                n_fail++;
                $display("FAIL restart cyc=%0d: got d=%h dp=%b an=%b t=%b, want d=%h dp=%b an=%b t=%b",
                         i, digit, dp_out, AN, frame_tick, exp_digit, exp_dp, exp_an, exp_tick);
            end
        end
    endtask

    task automatic test_random();
        int          lead;
        int          hold;
        logic [15:0] v;
        hold = 0;
        for (int i = 0; i < 320; i++) begin
            if (hold == 0) begin
                lead = $urandom_range(0, 4);
                v    = 16'($urandom);
                if (lead == 4) v = 16'h0;
                else v = v & (16'hFFFF >> (4 * lead));
                value    = v;
                dp_mask  = 4'($urandom);
                lz_blank = 1'($urandom);
                hold     = $urandom_range(5, 45);
            end
            hold--;
            step();
            n_cmp++;
            if ({digit, dp_out, AN, frame_tick} !== {exp_digit, exp_dp, exp_an, exp_tick}) begin
                n_fail++;
                $display("FAIL random cyc=%0d: got d=%h dp=%b an=%b t=%b, want d=%h dp=%b an=%b t=%b",
                         i, digit, dp_out, AN, frame_tick, exp_digit, exp_dp, exp_an, exp_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_lz_blank();
        test_zero_value();
        test_dp_and_hold();
        test_reset_mid_slot();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
